// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl
// Time-multiplexed scan scheduler for a shared seven-segment cathode bus.
// Each digit gets one DRIVE slot, separated by BLANK_TICKS ticks with all
// anodes off to avoid ghosting. New display data is staged in a pending
// buffer and only promoted to the active set at a frame boundary.
// Optional build macro: SEVEN_SEG_LEADING_ZERO_BLANK_EN turns off the anodes
// of leading zero digits (digit 0 is always shown).
//
// Load handshake: load_ready_o is high while the pending buffer is empty;
// data on digits_i/dp_i/digit_en_i is taken on any clock edge where
// load_valid_i and load_ready_o are both high. While ready is low, inputs
// are ignored and the producer is expected to keep valid asserted.

module seven_seg_scan_ctrl #(
    parameter int DIGITS_NUM  = 4,
    parameter int BLANK_TICKS = 1
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    tick_en_i,
    input  logic                    load_valid_i,
    output logic                    load_ready_o,
    input  logic [4*DIGITS_NUM-1:0] digits_i,
    input  logic [DIGITS_NUM-1:0]   dp_i,
    input  logic [DIGITS_NUM-1:0]   digit_en_i,
    output logic [DIGITS_NUM-1:0]   an_o,
    output logic [6:0]              seg_o,
    output logic                    dp_o,
    output logic                    frame_done_o
);

    localparam int IDX_W = (DIGITS_NUM > 1) ? $clog2(DIGITS_NUM) : 1;
    localparam int CNT_W = (BLANK_TICKS > 1) ? $clog2(BLANK_TICKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS_NUM - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLANK_TICKS - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        index_q, index_d;
    logic [CNT_W-1:0]        blank_cnt_q, blank_cnt_d;
    logic                    frame_end;

    logic [4*DIGITS_NUM-1:0] active_nib_q;
    logic [DIGITS_NUM-1:0]   active_dp_q;
    logic [DIGITS_NUM-1:0]   active_en_q;
    logic [4*DIGITS_NUM-1:0] pend_nib_q;
    logic [DIGITS_NUM-1:0]   pend_dp_q;
    logic [DIGITS_NUM-1:0]   pend_en_q;
    logic                    pend_full_q;
    logic                    frame_done_q;

    logic                    load_fire;
    logic [DIGITS_NUM-1:0]   suppress;
    logic [3:0]              cur_nib;

    // Standard 0-F decode, active-high (bit 0 = segment a).
    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    assign load_ready_o = ~pend_full_q;
    assign load_fire    = load_valid_i & ~pend_full_q;
    assign frame_done_o = frame_done_q;

    // Scan FSM state register: slot index, blanking counter and state.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_BLANK;
            index_q     <= '0;
            blank_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            blank_cnt_q <= blank_cnt_d;
        end
    end

    // Next-state logic: only a tick moves the scan; frame_end marks the last DRIVE slot ending.
    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        blank_cnt_d = blank_cnt_q;
        frame_end   = 1'b0;
        if (tick_en_i) begin
            case (state_q)
                ST_BLANK: begin
                    if (blank_cnt_q == LAST_CNT) begin
                        blank_cnt_d = '0;
                        state_d     = ST_DRIVE;
                    end else begin
                        blank_cnt_d = blank_cnt_q + 1'b1;
                    end
                end
                ST_DRIVE: begin
                    state_d = ST_BLANK;
                    if (index_q == LAST_IDX) begin
                        index_d   = '0;
                        frame_end = 1'b1;
                    end else begin
                        index_d = index_q + 1'b1;
                    end
                end
                default: state_d = ST_BLANK;
            endcase
        end
    end

    // Pending/active display buffers; a load and a promotion can never coincide since ready implies empty.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            active_nib_q <= '0;
            active_dp_q  <= '0;
            active_en_q  <= '0;
            pend_nib_q   <= '0;
            pend_dp_q    <= '0;
            pend_en_q    <= '0;
            pend_full_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= frame_end;
            if (load_fire) begin
                pend_nib_q  <= digits_i;
                pend_dp_q   <= dp_i;
                pend_en_q   <= digit_en_i;
                pend_full_q <= 1'b1;
            end else if (frame_end && pend_full_q) begin
                active_nib_q <= pend_nib_q;
                active_dp_q  <= pend_dp_q;
                active_en_q  <= pend_en_q;
                pend_full_q  <= 1'b0;
            end
        end
    end

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    logic lz_zero_above;
    logic lz_nib_zero;

    // Leading-zero mask: walk from the top digit down, stopping at the first enabled non-blank digit.
    always_comb begin
        suppress      = '0;
        lz_zero_above = 1'b1;
        lz_nib_zero   = 1'b0;
        for (int k = DIGITS_NUM - 1; k >= 0; k--) begin
            lz_nib_zero = (active_nib_q[4*k +: 4] == 4'h0) && !active_dp_q[k];
            if (k != 0) begin
                suppress[k] = lz_nib_zero && lz_zero_above;
            end
            if (active_en_q[k] && !lz_nib_zero) begin
                lz_zero_above = 1'b0;
            end
        end
    end
`else
    assign suppress = '0;
`endif

    assign cur_nib = active_nib_q[{index_q, 2'b00} +: 4];

    // Output decode: all dark in BLANK, one anode and its cathode pattern in DRIVE.
    always_comb begin
        an_o  = '1;
        seg_o = 7'h7F;
        dp_o  = 1'b1;
        if (state_q == ST_DRIVE) begin
            an_o[index_q] = ~(active_en_q[index_q] & ~suppress[index_q]);
            seg_o         = ~hex_decode(cur_nib);
            dp_o          = ~active_dp_q[index_q];
        end
    end

endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
- Time-multiplexing scheduler for the shared seven-segment cathode bus: grants the bus to one digit at a time, inserting blanking intervals between grants to prevent ghosting.
- Paced by the one-cycle tick from the clock-enable generator.
- Display data enters through a valid/ready load port and is applied only at frame boundaries, so a frame never tears.
- Sits between user logic (counters, registers) and the board anode/cathode pins.

Parameters:
- DIGITS_NUM, 4: number of multiplexed digits, 2..8.
- BLANK_TICKS, 1: ticks all anodes are held off between digits, at least 1.

Ports:
- clk_i  input  1  system clock
- reset_i  input  1  synchronous active-high reset
- tick_en_i  input  1  one-cycle scan pulse from the clock-enable generator
- load_valid_i  input  1  new display data offered
- load_ready_o  output  1  pending buffer empty; load accepted when valid&ready
- digits_i  input  4*DIGITS_NUM  hex nibble per digit; digit k at [4k+3:4k]
- dp_i  input  DIGITS_NUM  decimal point per digit, 1=on
- digit_en_i  input  DIGITS_NUM  per-digit enable, 1=shown
- an_o  output  DIGITS_NUM  anodes, active-low
- seg_o  output  7  cathodes a..g at bits 0..6, active-low
- dp_o  output  1  decimal-point cathode, active-low
- frame_done_o  output  1  one-cycle pulse when a frame completes

Behaviour:
- Reset is synchronous and active-high; clock is clk_i; no other clocks.
- Reset state: state=BLANK, index=0, blank_cnt=0, active nibbles/dp/en=0, pending empty.
- Output reset values: an_o all 1, seg_o=7'h7F, dp_o=1, load_ready_o=1, frame_done_o=0.
- The FSM advances only on cycles where tick_en_i=1. Between ticks, all state holds.
- BLANK state:
  - an_o all 1, seg_o=7'h7F, dp_o=1.
  - On tick with blank_cnt==BLANK_TICKS-1: blank_cnt<=0, go to DRIVE.
  - On any other tick: blank_cnt++.
- DRIVE state:
  - an_o[index]=~active_en[index]; all other anodes 1.
  - seg_o=~hexdecode(active_nibble[index]); dp_o=~active_dp[index].
  - A disabled digit shows all segments off, but its slot time is still consumed.
  - On tick: go to BLANK and set index<=index+1, wrapping DIGITS_NUM-1 to 0.
- Output timing: outputs are pure functions of registered state, with no extra pipeline stage. They change on the same edge as the state register.
- Hex decode is standard 0-F segment mapping: 0=7'h3F, 1=7'h06, 8=7'h7F, A=7'h77, F=7'h71 (active-high form, before inversion).
- Load port:
  - On valid&ready: digits_i/dp_i/digit_en_i are captured into pending, pending becomes full, and load_ready_o<=0.
  - Inputs are ignored when ready=0; the producer holds valid.
- Frame boundary = the DRIVE->BLANK tick with index==DIGITS_NUM-1. On that edge:
  - frame_done_o<=1 for exactly one cycle.
  - If pending is full: active<=pending, pending empties, load_ready_o<=1 from the next cycle.
- A load accepted on the boundary cycle itself (pending was empty) goes to pending and is promoted at the following boundary.
- Reset asserted mid-scan or with pending full: everything returns to reset values on the next edge, and pending data is discarded.
- tick_en_i asserted on consecutive cycles is legal: each cycle counts as one tick.

Optional Feature:
- Macro: SEVEN_SEG_LEADING_ZERO_BLANK_EN.
- Defined: while DRIVE, a digit is forced off (an_o bit 1) if its nibble is 0, its dp is 0, and every higher-index enabled digit is also 0 with dp 0. Digit 0 is never suppressed.
- Undefined: zeros are displayed normally.
- Slot timing is identical in both builds.

Test Plan:
- Reset check: DIGITS_NUM=4, BLANK_TICKS=1, tick every cycle, reset held 3 cycles -> an_o=4'hF, seg_o=7'h7F, dp_o=1, load_ready_o=1, frame_done_o=0. First DRIVE is on cycle 2 after release, index 0.
- Scan order: load 16'h4321, en=4'hF, tick every 4 cycles -> after promotion, an_o sequence E,F,D,F,B,F,7,F per tick. seg_o shows ~7'h06, ~7'h5B, ~7'h4F, ~7'h66 in the DRIVE slots. frame_done_o pulses once per 8 ticks.
- Tear-free update: load 16'hAAAA mid-frame -> load_ready_o drops and the displayed digits stay unchanged until the boundary. All four digits show ~7'h77 in the next frame. A second valid held during the wait stalls until ready=1.
- Boundary load: pending empty, valid on the boundary edge -> data is promoted one frame later, not immediately.
- Disable and reset: digit_en=4'b0101 -> digits 1 and 3 are never driven while slot timing is unchanged. Reset asserted in DRIVE of digit 2 with pending full -> reset values on the next edge, and the stale data never appears.
- Macro build: load 16'h0070, dp=0 -> digits 3 and 2 are blank, digit 1 shows 7, digit 0 shows 0. Without the macro, 0070 is displayed in full.
